image_writer: RTL and testbench
===============================

# image_writer

Sequential image writer for the NN input path. It accepts a stream of 8-bit pixels over a valid/ready handshake and writes them, one per cycle, into the 784-entry input-image memory at addresses 0..783. It then holds a frame-valid flag until the downstream pixel reader acknowledges the frame. It is the write-side counterpart of the pixel reader that scans the same memory at address 0 upward.

## Interface
Parameters:
- `NPIX`, 784: pixels per frame (28x28).
- `DW`, 8: pixel width.
- `AW`, 10: address width; 2**AW >= NPIX is required.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: begin loading a frame. Sampled only in IDLE.
- `in_valid`, in, 1: pixel on `in_data` is valid.
- `in_data`, in, DW: pixel value.
- `in_ready`, out, 1: writer accepts a pixel this cycle.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, AW: memory write address.
- `mem_din`, out, DW: memory write data.
- `frame_valid`, out, 1: a complete frame is in memory.
- `frame_ack`, in, 1: the reader has consumed the frame. Sampled only in DONE.
- `busy`, out, 1: high in LOAD.
- `cksum`, out, 16: pixel sum. Present only when `IMAGE_WRITER_CKSUM_EN` is defined.

## Operation
- The FSM has three states: IDLE, LOAD and DONE. Reset puts it in IDLE.
- IDLE -> LOAD when `start`=1. The pixel counter clears to 0 on this transition.
- LOAD:
  - `in_ready`=1.
  - A handshake is `in_valid && in_ready`. On each handshake, the pixel is registered to `mem_din`, the counter is registered to `mem_addr`, and `mem_we` is pulsed for one cycle.
  - The counter increments by 1 per handshake.
  - Stalls (`in_valid`=0) insert no write and do not advance the counter. Gaps of any length are legal.
- LOAD -> DONE on the handshake whose counter equals NPIX-1. The counter does not wrap past NPIX-1. `in_ready` drops in the same cycle as the transition.
- DONE:
  - `frame_valid`=1, `in_ready`=0.
  - `frame_ack`=1 -> IDLE, and `frame_valid` drops.
- Ignored inputs:
  - `start` in LOAD or DONE.
  - `frame_ack` in IDLE or LOAD.
  - `in_valid` outside LOAD.
- `start` and `frame_ack` asserted together in DONE: `frame_ack` takes effect and the FSM goes to IDLE. `start` is not latched, so a new frame needs `start` again in IDLE.
- Reset mid-LOAD abandons the partial frame. Memory contents are undefined and no `frame_valid` is produced.

## Timing
- Reset values:
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
  - `frame_valid`=0, `busy`=0, `cksum`=0.
  - Counter 0, state IDLE.
- `in_ready` and `busy` are registered, decoded from the state register. They go high the cycle after `start` is sampled.
- Write latency: a handshake in cycle N produces `mem_we`=1 with the matching address and data in cycle N+1.
- Throughput: 1 pixel/cycle. The minimum frame time is 784 cycles from the first handshake. `mem_we` for address 783 appears in the same cycle `frame_valid` rises.
- `frame_valid` falls one cycle after `frame_ack` is sampled in DONE. The earliest next `start` is sampled in that IDLE cycle.
- `mem_addr` and `mem_din` hold their last values when `mem_we`=0.

## Configuration
- `IMAGE_WRITER_CKSUM_EN` defined:
  - A 16-bit wrapping sum of all accepted pixels of the current frame is kept.
  - It clears on IDLE->LOAD and adds `in_data` on each handshake.
  - It is stable and valid while `frame_valid`=1 and is exposed on `cksum`.
- Not defined: no `cksum` port and no checksum logic. All other behaviour is identical.

## Structure
- Shared package `nn_pkg`:
  - Constants: `IMG_PIXELS`=784, `PIX_W`=8, `IMG_AW`=10.
  - State enum type `img_wr_state_t` (IDLE, LOAD, DONE).
  - The pixel reader uses the same constants.
- One sub-module, `pixel_addr_counter`: a load-clear/enable/terminal-count counter of width AW with terminal value NPIX-1.
- The FSM, write register stage and optional checksum live in `image_writer`.

## Test plan
- Reset then idle:
  - Hold `rst_n`=0 and drive `in_valid`=1 → all outputs 0, and no `mem_we` before `start`.
- Full back-to-back frame:
  - Stimulus: `start`, then `in_valid`=1 continuously with `in_data`=addr[7:0].
  - Required: exactly 784 `mem_we` pulses at addresses 0..783 with data = addr mod 256.
  - Required: `frame_valid` rises in the cycle of the write to address 783, and `in_ready`=0 from then on.
- Stalled stream:
  - Stimulus: `in_valid` toggles with a random pattern (~50%).
  - Required: still exactly 784 writes, addresses strictly sequential, no write in stall cycles.
- Handshake misuse:
  - `start` during LOAD at pixel 100 → ignored; the counter continues at 101.
  - `frame_ack` during LOAD → ignored.
  - `start` together with `frame_ack` in DONE → IDLE, with no new LOAD until `start` is asserted again.
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 after 300 pixels, release, `start`, then send a full frame.
  - Required: the first write after the restart is at address 0, and `frame_valid` appears only after 784 fresh pixels.
- Checksum (with `IMAGE_WRITER_CKSUM_EN`):
  - All pixels 0xFF → `cksum` = 784×255 mod 65536 = 0x0CF0 while `frame_valid`.
  - All pixels 0 → `cksum` = 0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and state type for the NN input-image path (writer and pixel reader).
package nn_pkg;

  localparam int IMG_PIXELS = 784;
  localparam int PIX_W      = 8;
  localparam int IMG_AW     = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } img_wr_state_t;

endpackage

// File: rtl/pixel_addr_counter.sv
// Frame pixel counter: synchronous clear, count enable, saturates at NPIX-1 with a terminal flag.
module pixel_addr_counter
  import nn_pkg::*;
#(
  parameter int AW   = IMG_AW,
  parameter int NPIX = IMG_PIXELS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] cnt,
  output logic          tc
);

  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  logic [AW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, and the count parks on the last address rather than wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + AW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/image_writer.sv
// Streams NPIX pixels into the input-image memory, then holds frame_valid until frame_ack.
// Optional 16-bit pixel checksum output enabled by IMAGE_WRITER_CKSUM_EN.
module image_writer
  import nn_pkg::*;
#(
  parameter int NPIX = IMG_PIXELS,
  parameter int DW   = PIX_W,
  parameter int AW   = IMG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          frame_valid,
  input  logic          frame_ack,
`ifdef IMAGE_WRITER_CKSUM_EN
  output logic [15:0]   cksum,
`endif
  output logic          busy
);

  img_wr_state_t state_q;
  logic          in_ready_q;
  logic          busy_q;
  logic          frame_valid_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_din_q;

  logic          hs_s;
  logic          clr_s;
  logic [AW-1:0] cnt_s;
  logic          tc_s;

  // in_ready_q is only ever high in LOAD, so it doubles as the state qualifier
  assign hs_s  = in_valid && in_ready_q;
  assign clr_s = (state_q == IDLE) && start;

  pixel_addr_counter #(
    .AW   (AW),
    .NPIX (NPIX)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .en    (hs_s),
    .cnt   (cnt_s),
    .tc    (tc_s)
  );

  // Control FSM with registered handshake, status and memory-write outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (hs_s) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= cnt_s;
            mem_din_q  <= in_data;
            if (tc_s) begin
              state_q       <= DONE;
              in_ready_q    <= 1'b0;
              busy_q        <= 1'b0;
              frame_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (frame_ack) begin
            state_q       <= IDLE;
            frame_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          in_ready_q    <= 1'b0;
          busy_q        <= 1'b0;
          frame_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign frame_valid = frame_valid_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;

`ifdef IMAGE_WRITER_CKSUM_EN
  logic [15:0] cksum_q;

  // Wrapping sum of accepted pixels; frozen in DONE because no handshakes occur there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum_q <= 16'd0;
    end else if (clr_s) begin
      cksum_q <= 16'd0;
    end else if (hs_s) begin
      cksum_q <= cksum_q + 16'(in_data);
    end else begin
      cksum_q <= cksum_q;
    end
  end

  assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_image_writer.sv
// Scoreboard bench for image_writer: expected writes are queued by the driver, a monitor pops them.
module tb_image_writer;

  localparam int NPIX = 784;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_din;
  logic        frame_valid;
  logic        frame_ack;
  logic        busy;
`ifdef IMAGE_WRITER_CKSUM_EN
  logic [15:0] cksum;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] ck_model;

  typedef struct {
    int addr;
    int data;
  } exp_t;
  exp_t exp_q[$];

  image_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
`ifdef IMAGE_WRITER_CKSUM_EN
    .cksum       (cksum),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every memory write must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got write addr=%0d data=%0d, wanted no write (t=%0t)",
                 mem_addr, mem_din, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", int'(mem_addr), e.addr);
        check("wr_data", int'(mem_din), e.data);
        check("fv_at_write", int'(frame_valid), (e.addr == NPIX - 1) ? 1 : 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int k, input int mode);
    logic [31:0] kk;
    kk = k;
    case (mode)
      0:       return kk[7:0];
      1:       return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    ck_model = 16'd0;
    check("in_ready_after_start", int'(in_ready), 1);
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic send_frame(input int n, input int mode, input bit stall, input int misuse_at);
    for (int k = 0; k < n; k++) begin
      if (stall) begin
        for (int s = 0; s < 8 && $urandom_range(0, 1) == 1; s++) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom_range(0, 255));
          cyc();
        end
      end
      check("in_ready_load", int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = pix(k, mode);
      if (k == misuse_at) begin
        start     = 1'b1;
        frame_ack = 1'b1;
      end
      exp_q.push_back('{k, int'(pix(k, mode))});
      ck_model = ck_model + 16'(pix(k, mode));
      cyc();
      start     = 1'b0;
      frame_ack = 1'b0;
    end
  endtask

  task automatic finish_frame(input bit with_start);
    check("fv_done", int'(frame_valid), 1);
    check("in_ready_done", int'(in_ready), 0);
    check("busy_done", int'(busy), 0);
    check("queue_drained", exp_q.size(), 0);
`ifdef IMAGE_WRITER_CKSUM_EN
    check("cksum_done", int'(cksum), int'(ck_model));
`endif
    frame_ack = 1'b1;
    start     = with_start;
    cyc();
    frame_ack = 1'b0;
    start     = 1'b0;
    check("fv_after_ack", int'(frame_valid), 0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("idle_no_load_ready", int'(in_ready), 0);
      check("idle_no_load_busy", int'(busy), 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, wanted test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    frame_ack = 1'b0;
    ck_model  = 16'd0;

    // Reset with in_valid held high
    repeat (3) cyc();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_din", int'(mem_din), 0);
    check("rst_frame_valid", int'(frame_valid), 0);
    check("rst_busy", int'(busy), 0);
`ifdef IMAGE_WRITER_CKSUM_EN
    check("rst_cksum", int'(cksum), 0);
`endif
    rst_n = 1'b1;
    repeat (4) begin
      cyc();
      check("idle_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;

    // Full back-to-back frame, in_valid kept high past the end
    do_start();
    send_frame(NPIX, 0, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      check("post_frame_in_ready", int'(in_ready), 0);
      check("post_frame_fv", int'(frame_valid), 1);
      cyc();
    end
    in_valid = 1'b0;
`ifdef IMAGE_WRITER_CKSUM_EN
    check("cksum_ramp", int'(cksum), 32504);
`endif
    finish_frame(1'b0);

    // Stalled stream
    do_start();
    send_frame(NPIX, 0, 1'b1, -1);
    in_valid = 1'b0;
    cyc();
    finish_frame(1'b0);

    // start and frame_ack during LOAD at pixel 100; start+ack together in DONE
    do_start();
    send_frame(NPIX, 0, 1'b0, 100);
    in_valid = 1'b0;
    cyc();
    finish_frame(1'b1);

    // Reset after 300 pixels, then a fresh full frame
    do_start();
    send_frame(300, 0, 1'b0, -1);
    in_valid = 1'b0;
    cyc();
    check("partial_drained", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("midrst_fv", int'(frame_valid), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_mem_addr", int'(mem_addr), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    do_start();
    send_frame(NPIX, 0, 1'b1, -1);
    in_valid = 1'b0;
    cyc();
    finish_frame(1'b0);

`ifdef IMAGE_WRITER_CKSUM_EN
    do_start();
    send_frame(NPIX, 1, 1'b0, -1);
    in_valid = 1'b0;
    cyc();
    check("cksum_all_ff", int'(cksum), 16'h0CF0);
    finish_frame(1'b0);

    do_start();
    send_frame(NPIX, 2, 1'b1, -1);
    in_valid = 1'b0;
    cyc();
    check("cksum_all_zero", int'(cksum), 0);
    finish_frame(1'b0);
`endif

    repeat (2) cyc();
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
